ddr3_ba_lane_ctrl: RTL and testbench

Fabric-side driver for the DDR3 bank-address output lanes, sitting directly upstream of the BA I/O-delay/serializer block in the DDR PHY. Registers the per-phase bank address from the controller into the 4:1 TX data and output-enable words of each lane. Also runs a delay-line adjust sequencer that turns "move lane L by N taps" requests into correctly spaced MOVE/DIRECTION/LOAD pulses, tracking each lane's tap position and out-of-range status.

---
 rtl/ddr3_phy_pkg.sv | 20 ++
 rtl/ddr3_ba_delay_seq.sv | 153 +++++++++++++++
 rtl/ddr3_ba_lane_ctrl.sv | 78 +++++++
 tb/tb_ddr3_ba_lane_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_phy_pkg.sv
// ddr3_phy_pkg: shared DDR PHY types, widths and lane/phase packing helper.
package ddr3_phy_pkg;

    localparam int TAP_W  = 8;
    localparam int PHASES = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_MOVE,
        S_LOAD,
        S_SETTLE,
        S_DONE
    } seq_state_t;

    function automatic int lane_bit(input int lane, input int phase);
        return lane * PHASES + phase;
    endfunction

endpackage

// File: rtl/ddr3_ba_delay_seq.sv
// ddr3_ba_delay_seq: turns tap adjust requests into spaced MOVE/DIRECTION/LOAD
// pulses and tracks each lane's tap position and out-of-range result.
module ddr3_ba_delay_seq
    import ddr3_phy_pkg::*;
#(
    parameter int               NUM_LANES     = 3,
    parameter int               SETTLE_CYCLES = 4,
    parameter logic [TAP_W-1:0] INIT_TAP      = 8'd1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_adj_req,
    input  logic [1:0]                 i_adj_lane,
    input  logic                       i_adj_dir,
    input  logic                       i_adj_load,
    input  logic [TAP_W-1:0]           i_adj_steps,
    output logic                       o_adj_busy,
    output logic                       o_adj_done,
    output logic                       o_adj_err,
    output logic [TAP_W*NUM_LANES-1:0] o_lane_tap,
    output logic [NUM_LANES-1:0]       o_move,
    output logic [NUM_LANES-1:0]       o_direction,
    output logic [NUM_LANES-1:0]       o_load,
    input  logic [NUM_LANES-1:0]       i_out_of_range
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    seq_state_t           r_state;
    logic [1:0]           r_lane;
    logic                 r_dir;
    logic                 r_ld;
    logic [TAP_W-1:0]     r_rem;
    logic [CW-1:0]        r_cnt;
    logic [TAP_W-1:0]     r_tap [NUM_LANES];
    logic [NUM_LANES-1:0] r_move;
    logic [NUM_LANES-1:0] r_dir_o;
    logic [NUM_LANES-1:0] r_load;
    logic                 r_done;
    logic                 r_err;
    logic [NUM_LANES-1:0] w_lane_oh;
    logic [NUM_LANES-1:0] w_req_oh;
    logic                 w_oor;

    always_comb begin
        w_lane_oh  = '0;
        w_req_oh   = '0;
        o_lane_tap = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_lane_oh[i]                  = (r_lane == 2'(i));
            w_req_oh[i]                   = (i_adj_lane == 2'(i));
            o_lane_tap[i*TAP_W +: TAP_W]  = r_tap[i];
        end
        w_oor = |(i_out_of_range & w_lane_oh);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_lane  <= '0;
            r_dir   <= 1'b0;
            r_ld    <= 1'b0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_move  <= '0;
            r_dir_o <= '0;
            r_load  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) r_tap[i] <= INIT_TAP;
        end else begin
            r_move <= '0;
            r_load <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_adj_req) begin
                        r_lane <= i_adj_lane;
                        r_dir  <= i_adj_dir;
                        r_ld   <= i_adj_load;
                        r_rem  <= i_adj_steps;
                        if (w_req_oh == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (i_adj_load) begin
                            r_state <= S_LOAD;
                            r_load  <= w_req_oh;
                        end else if (i_adj_steps == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SETUP;
                            r_dir_o <= i_adj_dir ? w_req_oh : '0;
                        end
                    end
                end
                S_SETUP: begin
                    r_state <= S_MOVE;
                    r_move  <= w_lane_oh;
                end
                S_MOVE: begin
                    r_rem   <= r_rem - 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_SETTLE;
                end
                S_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt != SETTLE_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (w_oor) begin
                        // abandon any remaining steps; the tap stays where it was
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_LANES; i++) begin
                            if (w_lane_oh[i])
                                r_tap[i] <= r_ld  ? INIT_TAP :
                                            r_dir ? ((&r_tap[i]) ? r_tap[i] : r_tap[i] + 1'b1) :
                                                    ((r_tap[i] == '0) ? r_tap[i] : r_tap[i] - 1'b1);
                        end
                        if (r_ld || r_rem == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_MOVE;
                            r_move  <= w_lane_oh;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_dir_o <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_adj_busy  = (r_state != S_IDLE);
    assign o_adj_done  = r_done;
    assign o_adj_err   = r_err;
    assign o_move      = r_move;
    assign o_direction = r_dir_o;
    assign o_load      = r_load;

endmodule

// File: rtl/ddr3_ba_lane_ctrl.sv
// ddr3_ba_lane_ctrl: registers per-phase bank address into 4:1 TX/OE lane words
// and hosts the delay-line adjust sequencer.
module ddr3_ba_lane_ctrl
    import ddr3_phy_pkg::*;
#(
    parameter int               NUM_LANES     = 3,
    parameter int               SETTLE_CYCLES = 4,
    parameter logic [TAP_W-1:0] INIT_TAP      = 8'd1
) (
    input  logic                        i_fab_clk,
    input  logic                        i_reset_n,
    input  logic [NUM_LANES-1:0]        i_ba_p0,
    input  logic [NUM_LANES-1:0]        i_ba_p1,
    input  logic [NUM_LANES-1:0]        i_ba_p2,
    input  logic [NUM_LANES-1:0]        i_ba_p3,
    input  logic                        i_drive_en,
    output logic [PHASES*NUM_LANES-1:0] o_tx_data,
    output logic [PHASES*NUM_LANES-1:0] o_oe_data,
    input  logic                        i_adj_req,
    input  logic [1:0]                  i_adj_lane,
    input  logic                        i_adj_dir,
    input  logic                        i_adj_load,
    input  logic [TAP_W-1:0]            i_adj_steps,
    output logic                        o_adj_busy,
    output logic                        o_adj_done,
    output logic                        o_adj_err,
    output logic [TAP_W*NUM_LANES-1:0]  o_lane_tap,
    output logic [NUM_LANES-1:0]        o_delay_line_move,
    output logic [NUM_LANES-1:0]        o_delay_line_direction,
    output logic [NUM_LANES-1:0]        o_delay_line_load,
    input  logic [NUM_LANES-1:0]        i_delay_line_out_of_range
);

    logic [PHASES*NUM_LANES-1:0] r_tx;
    logic [PHASES*NUM_LANES-1:0] r_oe;

    // phase 0 sits in the lane's LSB so it leaves the serializer first
    always_ff @(posedge i_fab_clk) begin
        if (!i_reset_n) begin
            r_tx <= '0;
            r_oe <= '0;
        end else begin
            r_oe <= {(PHASES*NUM_LANES){i_drive_en}};
            for (int i = 0; i < NUM_LANES; i++) begin
                r_tx[lane_bit(i, 0)] <= i_ba_p0[i];
                r_tx[lane_bit(i, 1)] <= i_ba_p1[i];
                r_tx[lane_bit(i, 2)] <= i_ba_p2[i];
                r_tx[lane_bit(i, 3)] <= i_ba_p3[i];
            end
        end
    end

    assign o_tx_data = r_tx;
    assign o_oe_data = r_oe;

    ddr3_ba_delay_seq #(
        .NUM_LANES    (NUM_LANES),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .INIT_TAP     (INIT_TAP)
    ) u_seq (
        .i_clk         (i_fab_clk),
        .i_rst_n       (i_reset_n),
        .i_adj_req     (i_adj_req),
        .i_adj_lane    (i_adj_lane),
        .i_adj_dir     (i_adj_dir),
        .i_adj_load    (i_adj_load),
        .i_adj_steps   (i_adj_steps),
        .o_adj_busy    (o_adj_busy),
        .o_adj_done    (o_adj_done),
        .o_adj_err     (o_adj_err),
        .o_lane_tap    (o_lane_tap),
        .o_move        (o_delay_line_move),
        .o_direction   (o_delay_line_direction),
        .o_load        (o_delay_line_load),
        .i_out_of_range(i_delay_line_out_of_range)
    );

endmodule

// File: tb/tb_ddr3_ba_lane_ctrl.sv
// tb_ddr3_ba_lane_ctrl: randomized self-checking bench for ddr3_ba_lane_ctrl,
// comparing against a cycle-count model of the adjust sequencer.
module tb_ddr3_ba_lane_ctrl;

    localparam int         S    = 4;
    localparam logic [7:0] INIT = 8'd1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ba0, ba1, ba2, ba3;
    logic        drive_en;
    logic [11:0] tx, oe;
    logic        req, adir, aload;
    logic [1:0]  alane;
    logic [7:0]  asteps;
    logic        busy, done, err;
    logic [23:0] taps;
    logic [2:0]  mv, dirv, ld, oor;

    int vectors = 0;
    int miscompares = 0;
    int edges = 0;
    int model_tap [3];

    int   move_cyc[$], move_lane[$], load_cyc[$], load_lane[$], done_cyc[$];
    logic [2:0] move_dir[$];
    logic done_err[$];
    int   mv_base = 0;
    int   oor_after = -1;
    int   oor_lane = 0;

    ddr3_ba_lane_ctrl #(.NUM_LANES(3), .SETTLE_CYCLES(S), .INIT_TAP(INIT)) dut (
        .i_fab_clk                (clk),
        .i_reset_n                (rst_n),
        .i_ba_p0                  (ba0),
        .i_ba_p1                  (ba1),
        .i_ba_p2                  (ba2),
        .i_ba_p3                  (ba3),
        .i_drive_en               (drive_en),
        .o_tx_data                (tx),
        .o_oe_data                (oe),
        .i_adj_req                (req),
        .i_adj_lane               (alane),
        .i_adj_dir                (adir),
        .i_adj_load               (aload),
        .i_adj_steps              (asteps),
        .o_adj_busy               (busy),
        .o_adj_done               (done),
        .o_adj_err                (err),
        .o_lane_tap               (taps),
        .o_delay_line_move        (mv),
        .o_delay_line_direction   (dirv),
        .o_delay_line_load        (ld),
        .i_delay_line_out_of_range(oor)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges++;

    // a negedge falls inside cycle edges+1 (the cycle that the next edge ends)
    always @(negedge clk) begin
        for (int l = 0; l < 3; l++) begin
            if (mv[l]) begin
                move_cyc.push_back(edges + 1);
                move_lane.push_back(l);
                move_dir.push_back(dirv);
            end
            if (ld[l]) begin
                load_cyc.push_back(edges + 1);
                load_lane.push_back(l);
            end
        end
        if (done) begin
            done_cyc.push_back(edges + 1);
            done_err.push_back(err);
        end
        oor = (oor_after > 0 && move_cyc.size() - mv_base >= oor_after) ? 3'(1 << oor_lane) : 3'b000;
    end

    task automatic check_taps(input string name);
        for (int l = 0; l < 3; l++) begin
            vectors++;
            if (taps[l*8 +: 8] !== 8'(model_tap[l])) begin
                miscompares++;
                $display("FAIL %s tap[%0d] got %0d exp %0d", name, l, taps[l*8 +: 8], model_tap[l]);
            end
        end
    endtask

    task automatic run_adjust(input int lane, input bit dir, input bit ldf, input int steps,
                              input int oor_m, input string name);
        int k, d0, l0, exp_done, n_mv, n_upd;
        bit exp_err, bad;
        bad = (lane >= 3);
        @(negedge clk);
        mv_base = move_cyc.size();
        l0 = load_cyc.size();
        d0 = done_cyc.size();
        oor_after = oor_m;
        oor_lane = bad ? 0 : lane;
        req = 1'b1; alane = 2'(lane); adir = dir; aload = ldf; asteps = 8'(steps);
        k = edges + 1;
        @(negedge clk);
        req = 1'b0;
        for (int t = 0; t < 3000 && done_cyc.size() == d0; t++) @(negedge clk);
        repeat (S + 4) @(negedge clk);
        oor_after = -1;
        n_mv = 0; n_upd = 0; exp_err = 1'b0;
        if (bad) begin
            exp_done = k + 1; exp_err = 1'b1;
        end else if (ldf) begin
            exp_done = k + 2 + S;
            model_tap[lane] = INIT;
        end else if (steps == 0) begin
            exp_done = k + 1;
        end else begin
            if (oor_m > 0 && oor_m <= steps) begin
                n_mv = oor_m; n_upd = oor_m - 1; exp_err = 1'b1;
            end else begin
                n_mv = steps; n_upd = steps;
            end
            exp_done = k + 2 + n_mv * (S + 1);
            for (int j = 0; j < n_upd; j++)
                model_tap[lane] = dir ? (model_tap[lane] < 255 ? model_tap[lane] + 1 : 255)
                                      : (model_tap[lane] > 0 ? model_tap[lane] - 1 : 0);
        end
        vectors++;
        if (done_cyc.size() - d0 != 1) begin
            miscompares++;
            $display("FAIL %s done_count got %0d exp 1", name, done_cyc.size() - d0);
        end else begin
            vectors++;
            if (done_cyc[d0] != exp_done || done_err[d0] !== exp_err) begin
                miscompares++;
                $display("FAIL %s done got cyc %0d err %b exp cyc %0d err %b", name,
                         done_cyc[d0] - k, done_err[d0], exp_done - k, exp_err);
            end
        end
        vectors++;
        if (move_cyc.size() - mv_base != n_mv) begin
            miscompares++;
            $display("FAIL %s move_count got %0d exp %0d", name, move_cyc.size() - mv_base, n_mv);
        end else begin
            for (int j = 0; j < n_mv; j++) begin
                vectors++;
                if (move_cyc[mv_base+j] != k + 2 + j * (S + 1) || move_lane[mv_base+j] != lane ||
                    move_dir[mv_base+j] !== (dir ? 3'(1 << lane) : 3'b000)) begin
                    miscompares++;
                    $display("FAIL %s move%0d got cyc %0d lane %0d dir %b exp cyc %0d lane %0d dir %b",
                             name, j, move_cyc[mv_base+j] - k, move_lane[mv_base+j], move_dir[mv_base+j],
                             2 + j * (S + 1), lane, dir ? 3'(1 << lane) : 3'b000);
                end
            end
        end
        vectors++;
        if (load_cyc.size() - l0 != ((ldf && !bad) ? 1 : 0)) begin
            miscompares++;
            $display("FAIL %s load_count got %0d exp %0d", name, load_cyc.size() - l0, (ldf && !bad) ? 1 : 0);
        end else if (ldf && !bad) begin
            vectors++;
            if (load_cyc[l0] != k + 1 || load_lane[l0] != lane) begin
                miscompares++;
                $display("FAIL %s load got cyc %0d lane %0d exp cyc 1 lane %0d", name,
                         load_cyc[l0] - k, load_lane[l0], lane);
            end
        end
        check_taps(name);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 1'b0; alane = '0; adir = 1'b0; aload = 1'b0; asteps = '0;
        drive_en = 1'b1; ba0 = 3'b111; ba1 = 3'b111; ba2 = 3'b111; ba3 = 3'b111;
        repeat (3) @(negedge clk);
        vectors++;
        if (tx !== 12'h000 || oe !== 12'h000 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
            mv !== 3'b000 || ld !== 3'b000 || dirv !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_outputs got tx %h oe %h busy %b done %b err %b mv %b ld %b dir %b exp all zero",
                     tx, oe, busy, done, err, mv, ld, dirv);
        end
        for (int l = 0; l < 3; l++) model_tap[l] = INIT;
        check_taps("reset_taps");
        rst_n = 1'b1;
    endtask

    task automatic test_datapath;
        logic [2:0]  bap [4];
        logic [11:0] exp_tx;
        drive_en = 1'b0; ba0 = 3'b101; ba1 = 3'b101; ba2 = 3'b101; ba3 = 3'b101;
        @(negedge clk);
        vectors++;
        if (tx !== 12'hF0F || oe !== 12'h000) begin
            miscompares++;
            $display("FAIL data_101 got tx %h oe %h exp tx f0f oe 000", tx, oe);
        end
        drive_en = 1'b1;
        @(negedge clk);
        vectors++;
        if (oe !== 12'hFFF) begin
            miscompares++;
            $display("FAIL oe_enable got %h exp fff", oe);
        end
        for (int n = 0; n < 24; n++) begin
            for (int p = 0; p < 4; p++) bap[p] = 3'($urandom);
            ba0 = bap[0]; ba1 = bap[1]; ba2 = bap[2]; ba3 = bap[3];
            drive_en = 1'($urandom);
            exp_tx = '0;
            for (int l = 0; l < 3; l++)
                for (int p = 0; p < 4; p++) exp_tx[l*4+p] = bap[p][l];
            @(negedge clk);
            vectors++;
            if (tx !== exp_tx || oe !== (drive_en ? 12'hFFF : 12'h000)) begin
                miscompares++;
                $display("FAIL data_rand%0d got tx %h oe %h exp tx %h oe %h", n, tx, oe, exp_tx,
                         drive_en ? 12'hFFF : 12'h000);
            end
        end
    endtask

    task automatic test_move;
        run_adjust(1, 1'b1, 1'b0, 3, -1, "move_lane1");
    endtask

    task automatic test_out_of_range;
        run_adjust(0, 1'b1, 1'b0, 5, 2, "oor_lane0");
    endtask

    task automatic test_load;
        run_adjust(2, 1'b1, 1'b0, 2, -1, "pre_load_move");
        run_adjust(2, 1'b0, 1'b1, 0, -1, "load_lane2");
    endtask

    task automatic test_bad_lane;
        run_adjust(3, 1'b1, 1'b0, 4, -1, "bad_lane");
        run_adjust(1, 1'b0, 1'b0, 0, -1, "zero_steps");
    endtask

    task automatic test_busy_drop;
        int k, d0, m0;
        @(negedge clk);
        d0 = done_cyc.size();
        m0 = move_cyc.size();
        req = 1'b1; alane = 2'd1; adir = 1'b1; aload = 1'b0; asteps = 8'd2;
        k = edges + 1;
        @(negedge clk);
        req = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_flag got %b exp 1", busy);
        end
        repeat (2) @(negedge clk);
        req = 1'b1; alane = 2'd0; adir = 1'b0; asteps = 8'd1;
        @(negedge clk);
        req = 1'b0;
        for (int t = 0; t < 300 && done_cyc.size() == d0; t++) @(negedge clk);
        repeat (12) @(negedge clk);
        model_tap[1] = model_tap[1] + 2;
        vectors++;
        if (done_cyc.size() - d0 != 1 || move_cyc.size() - m0 != 2) begin
            miscompares++;
            $display("FAIL busy_drop got dones %0d moves %0d exp dones 1 moves 2",
                     done_cyc.size() - d0, move_cyc.size() - m0);
        end else begin
            vectors++;
            if (done_cyc[d0] != k + 2 + 2 * (S + 1) || move_lane[m0] != 1 || move_lane[m0+1] != 1) begin
                miscompares++;
                $display("FAIL busy_drop_timing got done %0d lanes %0d %0d exp done %0d lanes 1 1",
                         done_cyc[d0] - k, move_lane[m0], move_lane[m0+1], 2 + 2 * (S + 1));
            end
        end
        check_taps("busy_drop");
    endtask

    task automatic test_saturation;
        run_adjust(2, 1'b0, 1'b0, 3, -1, "saturate_dec");
        vectors++;
        if (taps[23:16] !== 8'd0) begin
            miscompares++;
            $display("FAIL saturate_zero got %0d exp 0", taps[23:16]);
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        @(negedge clk);
        d0 = done_cyc.size();
        req = 1'b1; alane = 2'd1; adir = 1'b1; aload = 1'b0; asteps = 8'd3;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || mv !== 3'b000 || ld !== 3'b000 ||
            dirv !== 3'b000 || tx !== 12'h000 || oe !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_mid got busy %b done %b err %b mv %b ld %b dir %b tx %h oe %h exp all zero",
                     busy, done, err, mv, ld, dirv, tx, oe);
        end
        for (int l = 0; l < 3; l++) model_tap[l] = INIT;
        check_taps("reset_mid");
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        vectors++;
        if (done_cyc.size() != d0) begin
            miscompares++;
            $display("FAIL reset_mid_done got %0d dones exp 0", done_cyc.size() - d0);
        end
    endtask

    task automatic test_random_adjust;
        int lane, steps, oor_m;
        bit dir, ldf;
        for (int n = 0; n < 24; n++) begin
            lane  = $urandom_range(0, 3);
            dir   = 1'($urandom);
            ldf   = ($urandom_range(0, 3) == 0);
            steps = $urandom_range(0, 6);
            oor_m = (!ldf && steps > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, steps) : -1;
            run_adjust(lane, dir, ldf, steps, oor_m, $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_datapath();
        test_move();
        test_out_of_range();
        test_load();
        test_bad_lane();
        test_busy_drop();
        test_saturation();
        test_reset_mid();
        test_random_adjust();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
